mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning depth of the in-flight source-tag FIFO (power of two, >= 2).
REQ-002 SHALL have port clk_i  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have ports ireq_addr_i in 28 (memaddr_t), ireq_valid_i in 1, ireq_ready_o out 1: instruction request channel.
REQ-005 SHALL have ports iresp_addr_o out 28, iresp_data_o out 32 (word_t), iresp_valid_o out 1, iresp_ready_i in 1: instruction response channel.
REQ-006 SHALL have ports dreq_addr_i in 28, dreq_valid_i in 1, dreq_ready_o out 1: data request channel.
REQ-007 SHALL have ports dresp_addr_o out 28, dresp_data_o out 32, dresp_valid_o out 1, dresp_ready_i in 1: data response channel.
REQ-008 SHALL have ports mreq_addr_o out 28, mreq_valid_o out 1, mreq_ready_i in 1: shared memory request channel (instruction_cache-style, variable latency, in-order).
REQ-009 SHALL have ports mresp_addr_i in 28, mresp_data_i in 32, mresp_valid_i in 1, mresp_ready_o out 1: shared memory response channel.

Function
REQ-010 SHALL treat a transfer on any channel as valid && ready high in the same cycle.
REQ-011 SHALL select one requester per cycle (grant) among those with valid high; grant computation combinational, mreq_* driven combinationally from granted requester.
REQ-012 SHALL assert mreq_valid_o only when a requester is valid and tag FIFO not full; ready to granted requester = mreq_ready_i && !full; non-granted ready = 0.
REQ-013 SHALL hold grant (lock) while mreq_valid_o is high and not accepted, so mreq_addr_o stays stable until transfer.
REQ-014 SHALL push source tag (0=instruction, 1=data) into tag FIFO on every mreq transfer; zero-latency request path (no added cycles).
REQ-015 SHALL route mresp_* to the channel named by the FIFO head: that channel's resp_valid_o = mresp_valid_i, addr/data passed through; other channel resp_valid_o = 0.
REQ-016 SHALL drive mresp_ready_o = head channel's resp_ready_i when FIFO non-empty, 0 when empty; pop head on mresp transfer.
REQ-017 SHALL handle push and pop in same cycle: count unchanged, both pointers advance; pointers wrap modulo MAX_OUTSTANDING.
REQ-018 SHALL flag full at count == MAX_OUTSTANDING (all entries usable); simultaneous pop while full does not enable a push that cycle (full evaluated from registered count).
REQ-019 SHALL keep unselected channel's resp_addr_o/resp_data_o equal to mresp inputs (don't-care, valid low).

Reset
REQ-020 SHALL on rst_i high immediately clear tag FIFO pointers and count, lock flag, and last-grant register (last-grant = data).
REQ-021 SHALL hold ireq_ready_o, dreq_ready_o, mreq_valid_o, iresp_valid_o, dresp_valid_o, mresp_ready_o at 0 while rst_i high.
REQ-022 SHALL discard all in-flight tags on reset mid-operation; memory responses arriving after reset with empty FIFO are not accepted.

Configuration
REQ-023 SHALL, with macro MEM_ARBITER_ROUND_ROBIN_EN defined, arbitrate round-robin: when both valid and unlocked, grant the channel not granted at last mreq transfer; last-grant updates only on transfer.
REQ-024 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, use fixed priority: data over instruction whenever both valid and unlocked.

Verification
REQ-025 SHALL cover: only ireq_valid_i, addr 0x0000010, mreq_ready_i=1, response 2 cycles later data 0x00000013 -> iresp_valid_o=1 with addr 0x0000010, data 0x00000013; dresp_valid_o=0.
REQ-026 SHALL cover: both valid every cycle, mreq_ready_i=1, RR build -> mreq grants alternate I,D,I,D (first I); fixed build -> D every cycle, ireq_ready_o=0.
REQ-027 SHALL cover: mreq_ready_i=0 for 3 cycles with D granted, ireq_valid_i rising mid-stall -> mreq_addr_o constant, grant stays D until transfer.
REQ-028 SHALL cover: 4 requests issued, no responses (MAX_OUTSTANDING=4) -> 5th request sees ready 0; one response popped -> next cycle ready 1.
REQ-029 SHALL cover: head tag = D, dresp_ready_i=0, mresp_valid_i=1 -> mresp_ready_o=0, response held; dresp_ready_i=1 -> pop, next head routed.
REQ-030 SHALL cover: rst_i asserted with 2 tags in flight -> FIFO empty, all valid/ready outputs 0 asynchronously; late mresp_valid_i=1 -> mresp_ready_o=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-requester (instruction/data) arbiter in front of one
//            in-order memory port; a source-tag FIFO routes the responses.
//            Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin grant,
//            otherwise data has fixed priority over instruction.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [27:0] ireq_addr_i,
    input  logic        ireq_valid_i,
    output logic        ireq_ready_o,

    output logic [27:0] iresp_addr_o,
    output logic [31:0] iresp_data_o,
    output logic        iresp_valid_o,
    input  logic        iresp_ready_i,

    input  logic [27:0] dreq_addr_i,
    input  logic        dreq_valid_i,
    output logic        dreq_ready_o,

    output logic [27:0] dresp_addr_o,
    output logic [31:0] dresp_data_o,
    output logic        dresp_valid_o,
    input  logic        dresp_ready_i,

    output logic [27:0] mreq_addr_o,
    output logic        mreq_valid_o,
    input  logic        mreq_ready_i,

    input  logic [27:0] mresp_addr_i,
    input  logic [31:0] mresp_data_i,
    input  logic        mresp_valid_i,
    output logic        mresp_ready_o
);

    localparam int               C_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int               C_CNT_W = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(MAX_OUTSTANDING);
    localparam logic             C_SRC_I = 1'b0;
    localparam logic             C_SRC_D = 1'b1;

    logic               tag_q [MAX_OUTSTANDING];
    logic [C_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [C_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [C_CNT_W-1:0] count_q, count_d;
    logic               lock_q, lock_d;
    logic               lock_src_q, lock_src_d;

    logic gnt;
    logic req_valid;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic last_gnt_q, last_gnt_d;
`endif

    // A stalled request keeps its grant so mreq_addr_o cannot change under it.
    always_comb begin
        gnt = C_SRC_I;
        if (lock_q) begin
            gnt = lock_src_q;
        end else if (ireq_valid_i && dreq_valid_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            gnt = ~last_gnt_q;
`else
            gnt = C_SRC_D;
`endif
        end else if (dreq_valid_i) begin
            gnt = C_SRC_D;
        end
    end

    assign full      = (count_q == C_FULL);
    assign empty     = (count_q == '0);
    assign req_valid = (gnt == C_SRC_D) ? dreq_valid_i : ireq_valid_i;

    assign mreq_valid_o = !rst_i && req_valid && !full;
    assign mreq_addr_o  = (gnt == C_SRC_D) ? dreq_addr_i : ireq_addr_i;
    assign ireq_ready_o = !rst_i && (gnt == C_SRC_I) && mreq_ready_i && !full;
    assign dreq_ready_o = !rst_i && (gnt == C_SRC_D) && mreq_ready_i && !full;
    assign push         = mreq_valid_o && mreq_ready_i;

    assign head          = tag_q[rd_ptr_q];
    assign iresp_valid_o = !rst_i && !empty && (head == C_SRC_I) && mresp_valid_i;
    assign dresp_valid_o = !rst_i && !empty && (head == C_SRC_D) && mresp_valid_i;
    assign mresp_ready_o = !rst_i && !empty && ((head == C_SRC_D) ? dresp_ready_i : iresp_ready_i);
    assign pop           = mresp_valid_i && mresp_ready_o;

    assign iresp_addr_o = mresp_addr_i;
    assign iresp_data_o = mresp_data_i;
    assign dresp_addr_o = mresp_addr_i;
    assign dresp_data_o = mresp_data_i;

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + C_PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + C_PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        lock_d     = mreq_valid_o && !mreq_ready_i;
        lock_src_d = gnt;
        case ({push, pop})
            2'b10:   count_d = count_q + C_CNT_W'(1);
            2'b01:   count_d = count_q - C_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= C_SRC_I;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
        end
    end

    // Tag storage needs no reset: the pointers and count define what is live.
    always_ff @(posedge clk_i) begin
        if (push) begin
            tag_q[wr_ptr_q] <= gnt;
        end
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    assign last_gnt_d = push ? gnt : last_gnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_gnt_q <= C_SRC_D;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking scoreboard bench for mem_arbiter (either build of
//            MEM_ARBITER_ROUND_ROBIN_EN).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [27:0] ireq_addr_i, dreq_addr_i, mresp_addr_i;
    logic        ireq_valid_i, dreq_valid_i, mresp_valid_i;
    logic        iresp_ready_i, dresp_ready_i, mreq_ready_i;
    logic [31:0] mresp_data_i;
    logic        ireq_ready_o, dreq_ready_o, mreq_valid_o, mresp_ready_o;
    logic        iresp_valid_o, dresp_valid_o;
    logic [27:0] iresp_addr_o, dresp_addr_o, mreq_addr_o;
    logic [31:0] iresp_data_o, dresp_data_o;

    typedef struct packed {
        logic        src;
        logic [27:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    mem_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ireq_addr_i(ireq_addr_i), .ireq_valid_i(ireq_valid_i), .ireq_ready_o(ireq_ready_o),
        .iresp_addr_o(iresp_addr_o), .iresp_data_o(iresp_data_o),
        .iresp_valid_o(iresp_valid_o), .iresp_ready_i(iresp_ready_i),
        .dreq_addr_i(dreq_addr_i), .dreq_valid_i(dreq_valid_i), .dreq_ready_o(dreq_ready_o),
        .dresp_addr_o(dresp_addr_o), .dresp_data_o(dresp_data_o),
        .dresp_valid_o(dresp_valid_o), .dresp_ready_i(dresp_ready_i),
        .mreq_addr_o(mreq_addr_o), .mreq_valid_o(mreq_valid_o), .mreq_ready_i(mreq_ready_i),
        .mresp_addr_i(mresp_addr_i), .mresp_data_i(mresp_data_i),
        .mresp_valid_i(mresp_valid_i), .mresp_ready_o(mresp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_data(input logic [27:0] a);
        return {4'h0, a} + 32'h3;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        ireq_valid_i  = 1'b0; dreq_valid_i = 1'b0; mresp_valid_i = 1'b0;
        ireq_addr_i   = '0;   dreq_addr_i  = '0;   mresp_addr_i  = '0;
        mresp_data_i  = '0;
        iresp_ready_i = 1'b1; dresp_ready_i = 1'b1; mreq_ready_i = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        sb_q.delete();
    endtask

    task automatic check_all_quiet(input string tag);
        check_value({tag, "_irdy"},   ireq_ready_o,  1'b0);
        check_value({tag, "_drdy"},   dreq_ready_o,  1'b0);
        check_value({tag, "_mvalid"}, mreq_valid_o,  1'b0);
        check_value({tag, "_ivalid"}, iresp_valid_o, 1'b0);
        check_value({tag, "_dvalid"}, dresp_valid_o, 1'b0);
        check_value({tag, "_mrdy"},   mresp_ready_o, 1'b0);
    endtask

    // Checks the request side this cycle and records an expected response on transfer.
    task automatic expect_req(input string tag, input logic exp_valid,
                              input logic exp_src, input logic [27:0] exp_addr);
        exp_t e;
        settle();
        check_value({tag, "_mvalid"}, mreq_valid_o, exp_valid);
        if (exp_valid) check_value({tag, "_maddr"}, mreq_addr_o, exp_addr);
        check_value({tag, "_irdy"}, ireq_ready_o, exp_valid && !exp_src && mreq_ready_i);
        check_value({tag, "_drdy"}, dreq_ready_o, exp_valid &&  exp_src && mreq_ready_i);
        if (exp_valid && mreq_ready_i) begin
            e.src  = exp_src;
            e.addr = exp_addr;
            e.data = model_data(exp_addr);
            sb_q.push_back(e);
        end
        step();
    endtask

    task automatic expect_resp(input string tag);
        exp_t e;
        check_value({tag, "_sb_nonempty"}, sb_q.size() != 0, 1'b1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        mresp_valid_i = 1'b1; mresp_addr_i = e.addr; mresp_data_i = e.data;
        iresp_ready_i = 1'b1; dresp_ready_i = 1'b1;
        settle();
        check_value({tag, "_mrdy"},   mresp_ready_o, 1'b1);
        check_value({tag, "_ivalid"}, iresp_valid_o, !e.src);
        check_value({tag, "_dvalid"}, dresp_valid_o, e.src);
        check_value({tag, "_addr"}, e.src ? dresp_addr_o : iresp_addr_o, e.addr);
        check_value({tag, "_data"}, e.src ? dresp_data_o : iresp_data_o, e.data);
        step();
        mresp_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        logic src;
        idle_inputs();
        ireq_valid_i = 1'b1; dreq_valid_i = 1'b1; mresp_valid_i = 1'b1;
        repeat (2) @(posedge clk_i);
        settle();
        check_all_quiet("reset");
        step();
        rst_i = 1'b0;
        idle_inputs();

        // Single instruction fetch, response two cycles later.
        ireq_valid_i = 1'b1; ireq_addr_i = 28'h0000010;
        expect_req("i_single", 1'b1, 1'b0, 28'h0000010);
        ireq_valid_i = 1'b0;
        step();
        expect_resp("i_single_resp");

        // Both requesters valid every cycle.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ireq_valid_i = 1'b1; ireq_addr_i = 28'h100 + 28'(k);
            dreq_valid_i = 1'b1; dreq_addr_i = 28'h200 + 28'(k);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            src = (k % 2 == 1);
`else
            src = 1'b1;
`endif
            expect_req("both", 1'b1, src, src ? dreq_addr_i : ireq_addr_i);
        end
        ireq_valid_i = 1'b0; dreq_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) expect_resp("both_resp");

        // Stalled data grant stays locked while instruction arrives.
        do_reset();
        dreq_valid_i = 1'b1; dreq_addr_i = 28'h0000ABC; mreq_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                ireq_valid_i = 1'b1; ireq_addr_i = 28'h0000123;
            end
            expect_req("stall", 1'b1, 1'b1, 28'h0000ABC);
        end
        mreq_ready_i = 1'b1;
        expect_req("stall_go", 1'b1, 1'b1, 28'h0000ABC);
        dreq_valid_i = 1'b0;
        expect_req("after_stall", 1'b1, 1'b0, 28'h0000123);
        ireq_valid_i = 1'b0;

        // Head response for data held by dresp backpressure.
        mresp_valid_i = 1'b1; mresp_addr_i = 28'h0000ABC; mresp_data_i = model_data(28'h0000ABC);
        dresp_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            check_value("held_mrdy",   mresp_ready_o, 1'b0);
            check_value("held_dvalid", dresp_valid_o, 1'b1);
            check_value("held_ivalid", iresp_valid_o, 1'b0);
            step();
        end
        expect_resp("held_release");
        expect_resp("next_head");

        // FIFO full: fifth request blocked until a response drains.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ireq_valid_i = 1'b1; ireq_addr_i = 28'h300 + 28'(k);
            expect_req("fill", 1'b1, 1'b0, ireq_addr_i);
        end
        ireq_addr_i = 28'h304;
        expect_req("full", 1'b0, 1'b0, 28'h304);
        e = sb_q.pop_front();
        mresp_valid_i = 1'b1; mresp_addr_i = e.addr; mresp_data_i = e.data;
        settle();
        check_value("full_pop_mrdy",   mresp_ready_o, 1'b1);
        check_value("full_pop_ivalid", iresp_valid_o, 1'b1);
        check_value("full_pop_irdy",   ireq_ready_o,  1'b0);
        check_value("full_pop_mvalid", mreq_valid_o,  1'b0);
        step();
        mresp_valid_i = 1'b0;
        expect_req("after_pop", 1'b1, 1'b0, 28'h304);
        ireq_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) expect_resp("drain");

        // Asynchronous reset with two tags in flight.
        do_reset();
        ireq_valid_i = 1'b1; ireq_addr_i = 28'h400;
        expect_req("pre_rst_i", 1'b1, 1'b0, 28'h400);
        ireq_valid_i = 1'b0; dreq_valid_i = 1'b1; dreq_addr_i = 28'h500;
        expect_req("pre_rst_d", 1'b1, 1'b1, 28'h500);
        #2;
        ireq_valid_i = 1'b1; dreq_valid_i = 1'b1;
        mresp_valid_i = 1'b1; mresp_addr_i = 28'h400; mresp_data_i = model_data(28'h400);
        rst_i = 1'b1;
        #1;
        check_all_quiet("async_rst");
        sb_q.delete();
        step();
        rst_i = 1'b0; ireq_valid_i = 1'b0; dreq_valid_i = 1'b0;
        settle();
        check_value("late_resp_mrdy",   mresp_ready_o, 1'b0);
        check_value("late_resp_ivalid", iresp_valid_o, 1'b0);
        check_value("late_resp_dvalid", dresp_valid_o, 1'b0);
        step();
        mresp_valid_i = 1'b0;
        dreq_valid_i = 1'b1; dreq_addr_i = 28'h600;
        expect_req("post_rst", 1'b1, 1'b1, 28'h600);
        dreq_valid_i = 1'b0;
        expect_resp("post_rst_resp");

        check_value("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
